prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
- Fetch/issue controller that runs the processor core from a synchronous program memory.
- Holds the program counter and fetches one instruction word per step.
- Splits the word into opcode, destination, source and immediate-select fields, and issues it to the core with a valid pulse.
- Waits for the core's result-valid. Resolves NOP, BRA and HLT locally; these are never issued.
- Sits between the program ROM and the processor core; replaces free-running program feeding.

Parameters:
- BUSW, 8, operand field width.
- OPW, 4, opcode width.
- PCW, 8, program counter / memory address width.
- PROGLEN, 16, number of valid program lines (1..2^PCW).
- PSRW, 5, core status width.
- CCW, 4, branch condition-code width (CCW <= BUSW, CCW <= PSRW).
- NOP, 4'h0, opcode: no operation.
- BRA, 4'h3, opcode: branch.
- HLT, 4'h8, opcode: halt.
- TMO, 64, watchdog limit in cycles (used only with the optional feature).
- Instruction word ILW = OPW+2*BUSW+1, split as follows:
  - [ILW-1:2*BUSW+1] opcode
  - [2*BUSW:BUSW+1] dst
  - [BUSW:1] src
  - [0] imm

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin execution at PC=0; sampled only in IDLE.
- imem_addr  out  PCW  program memory address.
- imem_rd  out  1  read strobe; data is valid the cycle after the strobe.
- imem_data  in  ILW  program word.
- op_valid  out  1  one-cycle issue pulse to the core.
- op_code  out  OPW  issued opcode; held until the next issue.
- dst_op  out  BUSW  issued destination field; held.
- src_op  out  BUSW  issued source field; held.
- src_is_imm  out  1  issued immediate flag; held.
- res_valid  in  1  core completion pulse.
- psr  in  PSRW  core status; sampled when res_valid=1.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE; stays high until start.
- err  out  1  set on bad branch target or watchdog trip; cleared on start.
- pc  out  PCW  current program counter.

Behaviour:
- Reset values (asynchronous, rst_n=0): state=IDLE, pc=0, psr_q=0, all outputs 0.
- States and transitions:
  - IDLE: wait for start=1, then go to FETCH; pc=0, err=0.
  - FETCH: imem_rd=1, imem_addr=pc; go to LATCH.
  - LATCH: register imem_data into instr_q; go to EXEC.
  - EXEC, by opcode:
    - HLT: go to DONE; pc unchanged.
    - NOP: pc+1.
    - BRA: cc = dst[CCW-1:0], target = src[PCW-1:0] (zero-extended if BUSW<PCW).
      - Taken if cc==0 or (cc & psr_q[CCW-1:0]) != 0.
      - Taken with target >= PROGLEN: err=1, go to DONE.
      - Taken otherwise: pc=target.
      - Not taken: pc+1.
    - Any other opcode: drive the op_* fields, pulse op_valid for one cycle, go to WAIT.
  - WAIT: on res_valid=1, psr_q <= psr, pc+1, go to FETCH. res_valid in any other state is ignored.
  - DONE: done=1; on start=1, go to FETCH with pc=0, err=0, psr_q=0.
- Next-pc rule (NOP, not-taken BRA, completed op): if pc == PROGLEN-1, go to DONE without fetching; else go to FETCH. pc never wraps.
- start during busy is ignored.
- Latency: an issued op takes 3 cycles from FETCH to op_valid, plus the core latency, plus 1 cycle to the next FETCH. NOP and not-taken BRA take 3 cycles each.
- Branch conditions use psr_q, the status of the most recently completed op; psr_q=0 before the first completion.
- Reset mid-operation: returns to IDLE immediately; a pending core result is discarded.

Optional Feature:
- Macro PROG_SEQUENCER_WATCHDOG_EN.
- Defined:
  - A counter of width clog2(TMO+1) clears on entry to WAIT and increments each cycle in WAIT.
  - If it reaches TMO without res_valid: err=1, go to DONE, pc holds the stalled op's address.
- Undefined: WAIT waits indefinitely; no counter logic is generated.

Test Plan:
- Straight line: program [ADD, XOR, HLT], core answers 2 cycles after each op_valid, start pulse -> exactly 2 op_valid pulses with matching fields, then done=1 with pc=2, err=0.
- End of program: PROGLEN=3, program [ADD, NOP, ADD] with no HLT -> 2 issues, done=1 with pc=2, no fetch at address 3.
- Branches:
  - psr sampled as 5'b00100 after ADD, then BRA cc=4'b0100 target=5 -> next imem_addr=5.
  - Same with cc=4'b0010 -> next imem_addr = pc+1.
  - cc=0 -> always taken.
- Bad target: BRA cc=0 target=PROGLEN -> err=1, done=1, no further op_valid.
- Reset mid-op: rst_n low during WAIT -> all outputs 0 asynchronously; a later res_valid is ignored; start restarts at pc=0.
- Watchdog (macro defined, TMO=4): core never answers -> err=1 and done=1 exactly 4 cycles after entering WAIT. With the macro undefined, the sequencer stays busy.

Source files
------------

// File: rtl/prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : prog_sequencer
// Brief    : Fetch/issue controller that steps the core through a program held
//            in synchronous ROM, resolving NOP/BRA/HLT locally.
// Options  : PROG_SEQUENCER_WATCHDOG_EN adds a WAIT-state timeout of TMO cycles.
// Revision : 1.0 - initial release
// ============================================================================
module prog_sequencer #(
  parameter int             BUSW    = 8,
  parameter int             OPW     = 4,
  parameter int             PCW     = 8,
  parameter int             PROGLEN = 16,
  parameter int             PSRW    = 5,
  parameter int             CCW     = 4,
  parameter logic [OPW-1:0] NOP     = 4'h0,
  parameter logic [OPW-1:0] BRA     = 4'h3,
  parameter logic [OPW-1:0] HLT     = 4'h8,
  parameter int             TMO     = 64,
  localparam int            ILW     = OPW + 2*BUSW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PCW-1:0]  imem_addr,
  output logic            imem_rd,
  input  logic [ILW-1:0]  imem_data,
  output logic            op_valid,
  output logic [OPW-1:0]  op_code,
  output logic [BUSW-1:0] dst_op,
  output logic [BUSW-1:0] src_op,
  output logic            src_is_imm,
  input  logic            res_valid,
  input  logic [PSRW-1:0] psr,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [PCW-1:0]  pc
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_FETCH = 3'd1;
  localparam logic [2:0] c_LATCH = 3'd2;
  localparam logic [2:0] c_EXEC  = 3'd3;
  localparam logic [2:0] c_WAIT  = 3'd4;
  localparam logic [2:0] c_DONE  = 3'd5;

  // One extra bit so PROGLEN == 2^PCW is representable in the bound check.
  localparam logic [PCW:0]   c_PROGLEN = (PCW+1)'(PROGLEN);
  localparam logic [PCW-1:0] c_LAST    = PCW'(PROGLEN - 1);

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [PCW-1:0]  r_pc;
  logic [ILW-1:0]  r_instr;
  logic [PSRW-1:0] r_psr;
  logic            r_err;
  logic            r_op_valid;
  logic [OPW-1:0]  r_op_code;
  logic [BUSW-1:0] r_dst;
  logic [BUSW-1:0] r_src;
  logic            r_imm;

  logic [OPW-1:0]  w_opc;
  logic [BUSW-1:0] w_dst;
  logic [BUSW-1:0] w_src;
  logic            w_imm;
  logic [CCW-1:0]  w_cc;
  logic [PCW-1:0]  w_tgt;
  logic            w_is_nop;
  logic            w_is_bra;
  logic            w_is_hlt;
  logic            w_issue;
  logic            w_taken;
  logic            w_tgt_ok;
  logic            w_step;
  logic            w_last;
  logic            w_wdt_trip;
  logic            w_unused_psr;

  assign w_opc = r_instr[ILW-1:2*BUSW+1];
  assign w_dst = r_instr[2*BUSW:BUSW+1];
  assign w_src = r_instr[BUSW:1];
  assign w_imm = r_instr[0];
  assign w_cc  = w_dst[CCW-1:0];

  generate
    if (BUSW >= PCW) begin : g_tgt_trunc
      assign w_tgt = w_src[PCW-1:0];
    end else begin : g_tgt_zext
      assign w_tgt = {{(PCW-BUSW){1'b0}}, w_src};
    end
  endgenerate

  assign w_is_nop     = (w_opc == NOP);
  assign w_is_bra     = (w_opc == BRA);
  assign w_is_hlt     = (w_opc == HLT);
  assign w_issue      = !(w_is_nop || w_is_bra || w_is_hlt);
  assign w_taken      = (w_cc == '0) || ((w_cc & r_psr[CCW-1:0]) != '0);
  assign w_tgt_ok     = ({1'b0, w_tgt} < c_PROGLEN);
  assign w_step       = w_is_nop || (w_is_bra && !w_taken);
  assign w_last       = (r_pc == c_LAST);
  assign w_unused_psr = ^r_psr;

`ifdef PROG_SEQUENCER_WATCHDOG_EN
  localparam int WDW = $clog2(TMO + 1);
  logic [WDW-1:0] r_wdt;

  // Counts cycles spent in WAIT; held at zero elsewhere so each entry starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_wdt <= '0;
    else if (r_state != c_WAIT) r_wdt <= '0;
    else                        r_wdt <= r_wdt + 1'b1;
  end

  assign w_wdt_trip = (r_wdt == WDW'(TMO - 1));
`else
  assign w_wdt_trip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (start) w_next = c_FETCH;
      c_FETCH: w_next = c_LATCH;
      c_LATCH: w_next = c_EXEC;
      c_EXEC: begin
        if (w_is_hlt)                  w_next = c_DONE;
        else if (w_step)               w_next = w_last ? c_DONE : c_FETCH;
        else if (w_is_bra)             w_next = w_tgt_ok ? c_FETCH : c_DONE;
        else                           w_next = c_WAIT;
      end
      c_WAIT: begin
        if (res_valid)                 w_next = w_last ? c_DONE : c_FETCH;
        else if (w_wdt_trip)           w_next = c_DONE;
      end
      c_DONE:  if (start) w_next = c_FETCH;
      default: w_next = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= '0;
      r_instr    <= '0;
      r_psr      <= '0;
      r_err      <= 1'b0;
      r_op_valid <= 1'b0;
      r_op_code  <= '0;
      r_dst      <= '0;
      r_src      <= '0;
      r_imm      <= 1'b0;
    end else begin
      r_op_valid <= 1'b0;
      case (r_state)
        c_IDLE, c_DONE: begin
          if (start) begin
            r_pc  <= '0;
            r_err <= 1'b0;
            r_psr <= '0;
          end
        end
        c_LATCH: r_instr <= imem_data;
        c_EXEC: begin
          // pc stays at the last line when the program runs off its end.
          if (w_step) begin
            if (!w_last) r_pc <= r_pc + 1'b1;
          end else if (w_is_bra) begin
            if (w_tgt_ok) r_pc  <= w_tgt;
            else          r_err <= 1'b1;
          end else if (w_issue) begin
            r_op_valid <= 1'b1;
            r_op_code  <= w_opc;
            r_dst      <= w_dst;
            r_src      <= w_src;
            r_imm      <= w_imm;
          end
        end
        c_WAIT: begin
          if (res_valid) begin
            r_psr <= psr;
            if (!w_last) r_pc <= r_pc + 1'b1;
          end else if (w_wdt_trip) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    imem_rd = (r_state == c_FETCH);
    busy    = (r_state != c_IDLE) && (r_state != c_DONE);
    done    = (r_state == c_DONE);
  end

  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign err        = r_err;
  assign op_valid   = r_op_valid;
  assign op_code    = r_op_code;
  assign dst_op     = r_dst;
  assign src_op     = r_src;
  assign src_is_imm = r_imm;

endmodule
`default_nettype wire

// File: tb/tb_prog_sequencer.sv
`default_nettype none
// Directed testbench for prog_sequencer: ROM model, core responder, per-feature tasks.
module tb_prog_sequencer;

  localparam int BUSW = 8, OPW = 4, PCW = 8, PSRW = 5, ILW = OPW + 2*BUSW + 1;
  localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_XOR = 4'h2, OP_BRA = 4'h3, OP_HLT = 4'h8;

  logic            clk = 1'b0;
  logic            rst_n, start, res_valid;
  logic [PSRW-1:0] psr;
  logic [ILW-1:0]  imem_data;
  logic [PCW-1:0]  imem_addr, pc;
  logic            imem_rd, op_valid, src_is_imm, busy, done, err;
  logic [OPW-1:0]  op_code;
  logic [BUSW-1:0] dst_op, src_op;

  int n_cmp = 0, n_err = 0, cyc = 0;
  int nfetch = 0, nops = 0;
  int fetch_addr [64];
  int fetch_cyc  [64];
  int op_cyc     [64];
  logic [ILW-1:0] op_log [64];
  logic [ILW-1:0] mem [256];
  logic            core_en = 1'b1;
  logic [PSRW-1:0] core_psr = '0;

  prog_sequencer #(.PROGLEN(16), .TMO(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .op_valid(op_valid), .op_code(op_code), .dst_op(dst_op), .src_op(src_op),
    .src_is_imm(src_is_imm), .res_valid(res_valid), .psr(psr),
    .busy(busy), .done(done), .err(err), .pc(pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (imem_rd === 1'b1 && nfetch < 64) begin
      fetch_addr[nfetch] = int'(imem_addr);
      fetch_cyc[nfetch]  = cyc;
      nfetch = nfetch + 1;
    end
    if (op_valid === 1'b1 && nops < 64) begin
      op_log[nops] = {op_code, dst_op, src_op, src_is_imm};
      op_cyc[nops] = cyc;
      nops = nops + 1;
    end
  end

  // Core model: answers two cycles after each issue pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (op_valid === 1'b1 && core_en) begin
        repeat (2) @(posedge clk);
        #1 res_valid = 1'b1; psr = core_psr;
        @(posedge clk);
        #1 res_valid = 1'b0;
      end
    end
  end

  function automatic logic [ILW-1:0] enc(input logic [3:0] op, input logic [7:0] d,
                                         input logic [7:0] s, input logic i);
    return {op, d, s, i};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic run_start();
    nfetch = 0; nops = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL %s_timeout: done never rose within %0d cycles", name, bound); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; res_valid = 1'b0; psr = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, err, op_valid, imem_rd, op_code, pc, imem_addr} !== '0) begin
      n_err++; $display("FAIL reset_outputs: busy=%b done=%b err=%b opv=%b rd=%b pc=%0d exp all 0",
                        busy, done, err, op_valid, imem_rd, pc);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL reset_idle: busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_straight_line();
    clear_mem(); core_psr = '0;
    mem[0] = enc(OP_ADD, 8'd3, 8'd5, 1'b0);
    mem[1] = enc(OP_XOR, 8'd7, 8'h2A, 1'b1);
    mem[2] = enc(OP_HLT, 8'd0, 8'd0, 1'b0);
    run_start();
    wait_done("straight", 100);
    n_cmp++; if (nops !== 2) begin n_err++; $display("FAIL straight_issues: got %0d exp 2", nops); end
    n_cmp++; if (op_log[0] !== enc(OP_ADD, 8'd3, 8'd5, 1'b0)) begin
      n_err++; $display("FAIL straight_op0: got %h exp %h", op_log[0], enc(OP_ADD, 8'd3, 8'd5, 1'b0)); end
    n_cmp++; if (op_log[1] !== enc(OP_XOR, 8'd7, 8'h2A, 1'b1)) begin
      n_err++; $display("FAIL straight_op1: got %h exp %h", op_log[1], enc(OP_XOR, 8'd7, 8'h2A, 1'b1)); end
    n_cmp++; if (op_cyc[0] - fetch_cyc[0] !== 3) begin
      n_err++; $display("FAIL straight_issue_lat: got %0d exp 3", op_cyc[0] - fetch_cyc[0]); end
    n_cmp++; if (fetch_cyc[1] - op_cyc[0] !== 3) begin
      n_err++; $display("FAIL straight_refetch_lat: got %0d exp 3", fetch_cyc[1] - op_cyc[0]); end
    n_cmp++; if (pc !== 8'd2 || err !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL straight_final: pc=%0d err=%b busy=%b exp 2 0 0", pc, err, busy); end
    n_cmp++; if (op_code !== OP_XOR || src_op !== 8'h2A) begin
      n_err++; $display("FAIL straight_hold: op=%h src=%h exp 2 2a", op_code, src_op); end
  endtask

  task automatic test_end_of_program();
    clear_mem();
    mem[13] = enc(OP_ADD, 8'd9, 8'd1, 1'b0);
    mem[15] = enc(OP_XOR, 8'd4, 8'd6, 1'b1);
    run_start();
    wait_done("endprog", 300);
    repeat (5) @(negedge clk);
    n_cmp++; if (nfetch !== 16 || fetch_addr[15] !== 15) begin
      n_err++; $display("FAIL endprog_fetches: count=%0d last=%0d exp 16 15", nfetch, fetch_addr[15]); end
    n_cmp++; if (nops !== 2) begin n_err++; $display("FAIL endprog_issues: got %0d exp 2", nops); end
    n_cmp++; if (pc !== 8'd15 || done !== 1'b1 || err !== 1'b0) begin
      n_err++; $display("FAIL endprog_final: pc=%0d done=%b err=%b exp 15 1 0", pc, done, err); end
  endtask

  task automatic test_branch_taken();
    clear_mem(); core_psr = 5'b00100;
    mem[0] = enc(OP_ADD, 8'd1, 8'd2, 1'b0);
    mem[1] = enc(OP_BRA, 8'h04, 8'd5, 1'b0);
    mem[2] = enc(OP_HLT, 8'd0, 8'd0, 1'b0);
    mem[5] = enc(OP_HLT, 8'd0, 8'd0, 1'b0);
    run_start();
    wait_done("bra_taken", 100);
    n_cmp++; if (nfetch !== 3 || fetch_addr[2] !== 5) begin
      n_err++; $display("FAIL bra_taken_addr: count=%0d addr=%0d exp 3 5", nfetch, fetch_addr[2]); end
    n_cmp++; if (pc !== 8'd5) begin n_err++; $display("FAIL bra_taken_pc: got %0d exp 5", pc); end
  endtask

  // Restart from DONE must clear the status left by the previous run.
  task automatic test_branch_psr_clear();
    clear_mem();
    mem[0] = enc(OP_BRA, 8'h04, 8'd5, 1'b0);
    mem[1] = enc(OP_HLT, 8'd0, 8'd0, 1'b0);
    mem[5] = enc(OP_HLT, 8'd0, 8'd0, 1'b0);
    run_start();
    wait_done("bra_psrclr", 100);
    n_cmp++; if (fetch_addr[1] !== 1 || pc !== 8'd1) begin
      n_err++; $display("FAIL bra_psrclr: addr=%0d pc=%0d exp 1 1", fetch_addr[1], pc); end
  endtask

  task automatic test_branch_not_taken();
    clear_mem(); core_psr = 5'b00100;
    mem[0] = enc(OP_ADD, 8'd1, 8'd2, 1'b0);
    mem[1] = enc(OP_BRA, 8'h02, 8'd5, 1'b0);
    mem[2] = enc(OP_HLT, 8'd0, 8'd0, 1'b0);
    mem[5] = enc(OP_HLT, 8'd0, 8'd0, 1'b0);
    run_start();
    wait_done("bra_nt", 100);
    n_cmp++; if (fetch_addr[2] !== 2 || pc !== 8'd2) begin
      n_err++; $display("FAIL bra_nt: addr=%0d pc=%0d exp 2 2", fetch_addr[2], pc); end
    n_cmp++; if (fetch_cyc[2] - fetch_cyc[1] !== 3) begin
      n_err++; $display("FAIL bra_nt_lat: got %0d exp 3", fetch_cyc[2] - fetch_cyc[1]); end
  endtask

  task automatic test_branch_always();
    clear_mem(); core_psr = 5'b00000;
    mem[0]  = enc(OP_ADD, 8'd1, 8'd2, 1'b0);
    mem[1]  = enc(OP_BRA, 8'h00, 8'd15, 1'b0);
    mem[2]  = enc(OP_HLT, 8'd0, 8'd0, 1'b0);
    mem[15] = enc(OP_HLT, 8'd0, 8'd0, 1'b0);
    run_start();
    wait_done("bra_always", 100);
    n_cmp++; if (fetch_addr[2] !== 15 || pc !== 8'd15 || err !== 1'b0) begin
      n_err++; $display("FAIL bra_always: addr=%0d pc=%0d err=%b exp 15 15 0", fetch_addr[2], pc, err); end
  endtask

  task automatic test_bad_target();
    clear_mem();
    mem[0] = enc(OP_BRA, 8'h00, 8'd16, 1'b0);
    mem[1] = enc(OP_ADD, 8'd1, 8'd1, 1'b0);
    run_start();
    wait_done("badtgt", 100);
    repeat (5) @(negedge clk);
    n_cmp++; if (err !== 1'b1 || done !== 1'b1 || pc !== 8'd0) begin
      n_err++; $display("FAIL badtgt_final: err=%b done=%b pc=%0d exp 1 1 0", err, done, pc); end
    n_cmp++; if (nops !== 0 || nfetch !== 1) begin
      n_err++; $display("FAIL badtgt_quiet: ops=%0d fetches=%0d exp 0 1", nops, nfetch); end
    mem[0] = enc(OP_HLT, 8'd0, 8'd0, 1'b0);
    run_start();
    n_cmp++; if (err !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL badtgt_restart: err=%b busy=%b exp 0 1", err, busy); end
    wait_done("badtgt_restart", 50);
  endtask

  task automatic test_reset_mid_op();
    bit seen = 0;
    clear_mem(); core_en = 1'b0;
    mem[0] = enc(OP_ADD, 8'd1, 8'd2, 1'b0);
    mem[1] = enc(OP_HLT, 8'd0, 8'd0, 1'b0);
    run_start();
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (op_valid === 1'b1) seen = 1;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL midrst_issue: op_valid=0 exp 1"); end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, err, op_valid, imem_rd, op_code, dst_op, src_op, pc} !== '0) begin
      n_err++; $display("FAIL midrst_async: busy=%b op=%h dst=%h pc=%0d exp all 0", busy, op_code, dst_op, pc);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 res_valid = 1'b1; psr = 5'h1F;
    @(posedge clk); #1 res_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || pc !== 8'd0) begin
      n_err++; $display("FAIL midrst_ignore: busy=%b done=%b pc=%0d exp 0 0 0", busy, done, pc); end
    core_en = 1'b1;
    run_start();
    wait_done("midrst_restart", 100);
    n_cmp++; if (fetch_addr[0] !== 0 || pc !== 8'd1 || nops !== 1) begin
      n_err++; $display("FAIL midrst_restart: addr=%0d pc=%0d ops=%0d exp 0 1 1", fetch_addr[0], pc, nops); end
  endtask

  task automatic test_watchdog();
    bit seen = 0;
    clear_mem(); core_en = 1'b0;
    mem[1] = enc(OP_ADD, 8'd1, 8'd2, 1'b0);
    mem[2] = enc(OP_HLT, 8'd0, 8'd0, 1'b0);
    run_start();
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (op_valid === 1'b1) seen = 1;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL wdt_issue: op_valid=0 exp 1"); end
`ifdef PROG_SEQUENCER_WATCHDOG_EN
    repeat (3) @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL wdt_early: done=%b exp 0", done); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || err !== 1'b1 || pc !== 8'd1) begin
      n_err++; $display("FAIL wdt_trip: done=%b err=%b pc=%0d exp 1 1 1", done, err, pc); end
`else
    repeat (20) @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      n_err++; $display("FAIL wdt_stall: busy=%b done=%b err=%b exp 1 0 0", busy, done, err); end
`endif
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    core_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_end_of_program();
    test_branch_taken();
    test_branch_psr_clear();
    test_branch_not_taken();
    test_branch_always();
    test_bad_target();
    test_reset_mid_op();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
